mac_arbiter: RTL and testbench
==============================

# mac_arbiter

Shares one signed 16x16 hardware multiplier (an external SB_MAC16 or a pipelined multiplier) between up to N DSP requesters, such as cores, the calibration stage or filters. The multiplier sits in the 12 MHz `clk` domain alongside the codec and calibration logic. The block arbitrates requests round-robin with a valid/ready handshake, issues operands to the multiplier, and routes each product back to its originator after a fixed pipeline latency. It also counts multiplies per `sample_clk` period and flags sample-budget overruns.

## Interface
- W, 16, operand width, bits; product width is 2W
- N, 4, number of requesters (2..8)
- MUL_LAT, 2, cycles from handshake to product valid (>=1); multiplier internal latency is MUL_LAT-1
- CW, 12, width of op counters
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  asynchronous, active-low reset
- sample_clk  in  1  one-cycle strobe per audio sample
- req_valid  in  N  per-requester request
- req_a  in  N*W  signed operand A, requester i at [i*W +: W]
- req_b  in  N*W  signed operand B, same packing
- req_ready  out  N  one-hot grant; handshake = valid & ready
- rsp_valid  out  N  one-hot, one-cycle product strobe
- rsp_data  out  2W  signed product, shared by all requesters
- mul_a  out  W  registered operand A to multiplier
- mul_b  out  W  registered operand B to multiplier
- mul_p  in  2W  product from multiplier
- ops_last  out  CW  multiplies accepted in the previous sample period
- overrun  out  1  sticky budget-overrun flag

## Operation
- **Arbitration**
  - Round-robin pointer `last` holds the last granted index; reset value N-1, so requester 0 wins first.
  - Each cycle, scan from last+1 cyclically and grant the first index with req_valid high.
  - req_ready is combinational from req_valid and `last`. At most one bit is set, and only when its req_valid is high.
  - On a handshake, `last` becomes the granted index. With no request, `last` holds.
- **Request rules**
  - A requester holds req_valid and its operands stable until it sees ready.
  - Withdrawing a request before ready is illegal. The block does not check it, and the bench must not do it.
  - At most one handshake per cycle, so throughput is 1 multiply/cycle.
- **Issue**
  - On a handshake at cycle t, the granted req_a and req_b are registered into mul_a and mul_b, visible at t+1.
  - With no handshake, mul_a and mul_b hold their previous values.
- **Tag pipeline**
  - Each stage has a valid bit and a clog2(N)-bit index, depth MUL_LAT.
  - Stage 0 loads on a handshake; otherwise its valid bit is 0.
  - When the last stage is valid, rsp_valid[idx] = 1; otherwise rsp_valid = 0.
  - rsp_data = mul_p, passed through combinationally. It is meaningful only while any rsp_valid bit is set.
  - There is no response backpressure; requesters must capture the product in the strobe cycle.
- **Budget counter**
  - `cnt` (CW bits) increments on each handshake and saturates at 2^CW-1.
  - On sample_clk: ops_last <= cnt + (handshake this cycle ? 1 : 0), saturating; cnt <= 0.
  - A handshake in the sample_clk cycle counts toward the closing period only.
- **Overrun**
  - Set on a sample_clk cycle if any req_valid bit is high with its req_ready low.
  - Cleared only by rst_n.

## Timing
- Reset (rst_n low, asynchronous) drives:
  - req_ready: combinational, governed by `last` = N-1
  - rsp_valid = 0 and all tag valid bits = 0
  - mul_a = 0, mul_b = 0
  - ops_last = 0, cnt = 0, overrun = 0
- Asserting reset mid-operation discards all in-flight tags; no rsp_valid follows for pre-reset handshakes.
- Latency: handshake at cycle t gives rsp_valid at cycle t+MUL_LAT.
- With continuous requests from all N, each requester is granted exactly once every N cycles.
- A single requester held valid is granted every cycle.
- Tag pipeline is fully pipelined with no bubbles; responses return in handshake order.

## Test plan
- **Single op:** reset; req_valid=4'b0001, a=300, b=-200 -> req_ready=0001 that cycle; rsp_valid=0001 exactly 2 cycles later; rsp_data=-60000; mul_a=300 one cycle after handshake.
- **Fairness:** all 4 valid for 12 cycles with a=i+1, b=2 -> grant order 0,1,2,3 repeated 3 times; each requester gets 3 responses of value 2(i+1), in order.
- **Pointer wrap:** only requesters 3 and 0 valid after granting 3 -> next grant 0, then 3; no skipped or duplicate grants.
- **Budget:** 100 handshakes, then sample_clk coinciding with the 101st handshake -> ops_last=101, cnt restarts from 0; 4095+ handshakes in a period -> ops_last=4095 (saturated).
- **Overrun:** requesters 1 and 2 valid in the cycle sample_clk pulses -> overrun=1 next cycle and stays 1 after requests drain; a sample_clk with only granted requests does not set it.
- **Reset mid-flight:** handshake at t, rst_n low at t+1 -> no rsp_valid at t+2; all outputs at reset values; after release, requester 0 has first priority.

Source files
------------

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among N requesters, with product routing
// by a tag pipeline and a per-sample-period multiply budget counter.
module mac_arbiter #(
  parameter int unsigned W       = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CW      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_clk,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     rsp_valid,
  output logic [2*W-1:0]   rsp_data,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic [CW-1:0]    ops_last,
  output logic             overrun
);

  localparam int unsigned   IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [IW-1:0] LastRst = IW'(N - 1);

  logic [IW-1:0]      last_q;
  logic [IW-1:0]      grant_idx;
  logic               hs;
  logic [MUL_LAT-1:0] tag_v_q;
  logic [IW-1:0]      tag_idx_q [MUL_LAT];
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_inc;

  // Scan cyclically starting just after the last granted index.
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cidx;
    cand      = 0;
    cidx      = '0;
    hs        = 1'b0;
    grant_idx = last_q;
    req_ready = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_q) + k) % N;
      cidx = IW'(cand);
      if (!hs && req_valid[cidx]) begin
        hs        = 1'b1;
        grant_idx = cidx;
      end
    end
    req_ready[grant_idx] = hs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LastRst;
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (hs) begin
      last_q <= grant_idx;
      mul_a  <= req_a[grant_idx*W +: W];
      mul_b  <= req_b[grant_idx*W +: W];
    end
  end

  // Tag stage MUL_LAT-1 lines up with the multiplier output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      tag_v_q[0]   <= hs;
      tag_idx_q[0] <= grant_idx;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_v_q[MUL_LAT-1]) rsp_valid[tag_idx_q[MUL_LAT-1]] = 1'b1;
  end

  assign rsp_data = mul_p;

  // Saturating cnt + handshake; a handshake on the sample strobe closes into ops_last.
  assign cnt_inc = (hs && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ops_last <= '0;
      overrun  <= 1'b0;
    end else begin
      if (sample_clk) begin
        ops_last <= cnt_inc;
        cnt_q    <= '0;
      end else begin
        cnt_q    <= cnt_inc;
      end
      if (sample_clk && |(req_valid & ~req_ready)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Randomized and directed bench for mac_arbiter: a per-cycle reference model drives a
// response scoreboard that an independent monitor drains.
module tb_mac_arbiter;

  localparam int unsigned W       = 16;
  localparam int unsigned N       = 4;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned CW      = 12;
  localparam longint      CMAX    = (longint'(1) << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_clk = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [2*W-1:0]   rsp_data;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic [CW-1:0]    ops_last;
  logic             overrun;

  mac_arbiter #(.W(W), .N(N), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .ops_last(ops_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in with MUL_LAT-1 cycles of latency.
  logic signed [2*W-1:0] mp [MUL_LAT-1];
  always @(posedge clk) begin
    mp[0] <= $signed(mul_a) * $signed(mul_b);
    for (int i = 1; i < MUL_LAT - 1; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[MUL_LAT-2];

  typedef struct {int idx; longint prod; int due;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: pending requests, pointer, counters, registered outputs.
  logic [N-1:0]          pend = '0;
  logic signed [W-1:0]   pa [N];
  logic signed [W-1:0]   pb [N];
  int                    m_last = N - 1;
  longint                m_cnt = 0;
  longint                e_ops = 0;
  logic                  e_ovr = 1'b0;
  logic [W-1:0]          e_mul_a = '0;
  logic [W-1:0]          e_mul_b = '0;

  task automatic chk(input string name, input logic ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic offer(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      pa[i]   = a;
      pb[i]   = b;
    end
  endtask

  task automatic step(input logic samp);
    int gi;
    logic [N-1:0] g;
    req_valid  = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
    sample_clk = samp;
    @(negedge clk);
    gi = rst_n ? pick(m_last, pend) : -1;
    g  = '0;
    if (gi >= 0) g[gi] = 1'b1;
    chk("req_ready", req_ready == g, req_ready, g);
    chk("mul_a", mul_a == e_mul_a, mul_a, e_mul_a);
    chk("mul_b", mul_b == e_mul_b, mul_b, e_mul_b);
    chk("ops_last", longint'(ops_last) == e_ops, ops_last, e_ops);
    chk("overrun", overrun == e_ovr, overrun, e_ovr);
    if (rst_n) begin
      if (samp && |(pend & ~g)) e_ovr = 1'b1;
      if (gi >= 0) begin
        sb.push_back('{idx: gi, prod: longint'(pa[gi]) * longint'(pb[gi]), due: cyc + MUL_LAT});
        e_mul_a = pa[gi];
        e_mul_b = pb[gi];
        m_last  = gi;
      end
      if (samp) begin
        e_ops = m_cnt + ((gi >= 0) ? 1 : 0);
        if (e_ops > CMAX) e_ops = CMAX;
        m_cnt = 0;
      end else if (gi >= 0 && m_cnt < CMAX) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (gi >= 0) pend[gi] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    pend    = '0;
    sb.delete();
    m_last  = N - 1;
    m_cnt   = 0;
    e_ops   = 0;
    e_ovr   = 1'b0;
    e_mul_a = '0;
    e_mul_b = '0;
    repeat (2) step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < N + 1 && pend != '0; k++) step(1'b0);
    repeat (MUL_LAT + 1) step(1'b0);
  endtask

  // Response monitor: expects a strobe exactly when the oldest entry falls due.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid == N'(1 << e.idx), rsp_valid, 1 << e.idx);
      chk("rsp_data", longint'($signed(rsp_data)) == e.prod, $signed(rsp_data), e.prod);
    end else begin
      chk("rsp_idle", rsp_valid == '0, rsp_valid, 0);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    do_reset();

    // Single op
    offer(0, 16'sd300, -16'sd200);
    step(1'b0);
    chk("single_mul_a", $signed(mul_a) == 300, $signed(mul_a), 300);
    drain();

    // Reset mid-flight: handshake then immediate reset; no response may follow
    offer(1, 16'sd5, 16'sd7);
    step(1'b0);
    do_reset();
    offer(2, 16'sd3, 16'sd3);
    offer(0, 16'sd4, 16'sd4);
    step(1'b0);
    drain();
    do_reset();

    // Fairness: all valid for 12 cycles
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) offer(i, 16'(i + 1), 16'sd2);
      step(1'b0);
    end
    drain();

    // Pointer wrap: only 3 and 0, last grant was 3
    for (int c = 0; c < 4; c++) begin
      offer(3, 16'sd11, -16'sd3);
      offer(0, -16'sd9, 16'sd9);
      step(1'b0);
    end
    drain();

    // Overrun: granted-only sample does not set; a waiting requester does
    offer(1, 16'sd1, 16'sd1);
    step(1'b1);
    chk("ovr_clear", overrun == 1'b0, overrun, 0);
    offer(1, 16'sd2, 16'sd2);
    offer(2, 16'sd3, 16'sd2);
    step(1'b1);
    chk("ovr_set", overrun == 1'b1, overrun, 1);
    drain();
    chk("ovr_sticky", overrun == 1'b1, overrun, 1);

    // Budget: 100 handshakes then the 101st on the sample strobe
    step(1'b1);
    for (int c = 0; c < 100; c++) begin
      offer(0, 16'(c), 16'sd3);
      step(1'b0);
    end
    offer(0, 16'sd1, 16'sd1);
    step(1'b1);
    chk("budget_101", ops_last == 101, ops_last, 101);
    for (int c = 0; c < 4100; c++) begin
      offer(0, 16'($urandom), 16'($urandom));
      step(1'b0);
    end
    step(1'b1);
    chk("budget_sat", longint'(ops_last) == CMAX, ops_last, CMAX);
    drain();

    // Random traffic with random sample strobes
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 40) offer(i, 16'($urandom), 16'($urandom));
      step($urandom_range(0, 39) == 0);
    end
    drain();
    chk("sb_empty", sb.size() == 0, sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
